cmp_result_display: RTL and testbench

- Downstream stage of the 4-bit comparator Top. Consumes its per-cycle result (out[1:0], seg7[7:0]).
- Keeps a shift history of the last DIGITS seg7 codes and time-multiplexes them onto a common-segment, active-low-anode 7-segment display.
- Maintains saturating tallies of greater, less and equal outcomes for readback.

---
 rtl/cmp_disp_pkg.sv | 23 ++
 rtl/cmp_disp_scan.sv | 67 ++++++
 rtl/cmp_result_display.sv | 140 ++++++++++++++
 tb/tb_cmp_result_display.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_disp_pkg.sv
// Shared types, constants and helpers for the comparator result display.
package cmp_disp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ  = 2'b00,
    CMP_GT  = 2'b01,
    CMP_LT  = 2'b10,
    CMP_RSV = 2'b11
  } cmp_e;

  localparam logic [7:0] DEF_BLANK_CODE = 8'hFF;

  // Index width for a counter over n values, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cmp_disp_scan.sv
// Digit scan timing: refresh divider, digit index and registered active-low anodes.
module cmp_disp_scan
  import cmp_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int IDX_W       = clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CMP_DISP_BLINK_EN
  output logic              frame_wrap,
`endif
  output logic [IDX_W-1:0]  idx,
  output logic [DIGITS-1:0] an
);

  localparam int              DIV_W    = clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  div_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic [DIGITS-1:0] an_r;

  // Next divider / digit index; idx only moves when the divider wraps.
  always_comb begin
    div_nxt_s = div_r;
    idx_nxt_s = idx_r;
    if (div_r == DIV_LAST) begin
      div_nxt_s = {DIV_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_nxt_s = {IDX_W{1'b0}};
      end else begin
        idx_nxt_s = idx_r + IDX_ONE;
      end
    end else begin
      div_nxt_s = div_r + DIV_ONE;
      idx_nxt_s = idx_r;
    end
  end

  // Scan state and anode register; anodes lag idx by one cycle like seg_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
      an_r  <= {DIGITS{1'b1}};
    end else begin
      div_r <= div_nxt_s;
      idx_r <= idx_nxt_s;
      an_r  <= ~(ONE_HOT0 << idx_r);
    end
  end

`ifdef CMP_DISP_BLINK_EN
  assign frame_wrap = (div_r == DIV_LAST) && (idx_r == IDX_LAST);
`endif
  assign idx = idx_r;
  assign an  = an_r;

endmodule

// File: rtl/cmp_result_display.sv
// Comparator result display: seg7 history scanned onto a multiplexed display plus outcome tallies.
// Optional digit-0 blink after each new entry is enabled with CMP_DISP_BLINK_EN.
module cmp_result_display
  import cmp_disp_pkg::*;
#(
  parameter int         DIGITS      = 4,
  parameter int         REFRESH_DIV = 50000,
  parameter int         CNT_W       = 8,
  parameter logic [7:0] BLANK_CODE  = DEF_BLANK_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        cmp_in,
  input  logic [7:0]        seg_in,
  input  logic              clr,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg_out,
  output logic [CNT_W-1:0]  gt_cnt,
  output logic [CNT_W-1:0]  lt_cnt,
  output logic [CNT_W-1:0]  eq_cnt
);

  localparam int               IDX_W   = clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [7:0]       hist_r [DIGITS];
  logic [CNT_W-1:0] gt_r;
  logic [CNT_W-1:0] lt_r;
  logic [CNT_W-1:0] eq_r;
  logic [7:0]       seg_r;
  logic [7:0]       seg_nxt_s;
  logic [IDX_W-1:0] idx_s;
  logic             hist_we_s;

  // Saturating tally increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  // clr has priority: a colliding valid input is dropped entirely.
  assign hist_we_s = in_valid & ~clr;

`ifdef CMP_DISP_BLINK_EN
  logic       frame_wrap_s;
  logic [3:0] blink_r;
`endif

  cmp_disp_scan #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .IDX_W       (IDX_W)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
`ifdef CMP_DISP_BLINK_EN
    .frame_wrap (frame_wrap_s),
`endif
    .idx        (idx_s),
    .an         (an)
  );

  // History shift register, newest entry in slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) hist_r[i] <= BLANK_CODE;
    end else if (clr) begin
      for (int i = 0; i < DIGITS; i++) hist_r[i] <= BLANK_CODE;
    end else if (hist_we_s) begin
      for (int i = DIGITS - 1; i > 0; i--) hist_r[i] <= hist_r[i-1];
      hist_r[0] <= seg_in;
    end
  end

  // Outcome tallies; reserved code is stored in history but not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_r <= {CNT_W{1'b0}};
      lt_r <= {CNT_W{1'b0}};
      eq_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      gt_r <= {CNT_W{1'b0}};
      lt_r <= {CNT_W{1'b0}};
      eq_r <= {CNT_W{1'b0}};
    end else if (hist_we_s) begin
      case (cmp_e'(cmp_in))
        CMP_GT:  gt_r <= sat_inc(gt_r);
        CMP_LT:  lt_r <= sat_inc(lt_r);
        CMP_EQ:  eq_r <= sat_inc(eq_r);
        default: ;
      endcase
    end
  end

`ifdef CMP_DISP_BLINK_EN
  // Frame blink counter: reloads on each write, counts down once per full scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_r <= 4'd0;
    end else if (clr) begin
      blink_r <= 4'd0;
    end else if (hist_we_s) begin
      blink_r <= 4'd8;
    end else if (frame_wrap_s && (blink_r != 4'd0)) begin
      blink_r <= blink_r - 4'd1;
    end
  end

  // Digit mux with digit 0 blanked on odd blink frames.
  always_comb begin
    seg_nxt_s = hist_r[idx_s];
    if ((idx_s == {IDX_W{1'b0}}) && blink_r[0]) begin
      seg_nxt_s = BLANK_CODE;
    end else begin
      seg_nxt_s = hist_r[idx_s];
    end
  end
`else
  // Digit mux: the selected history slot.
  always_comb begin
    seg_nxt_s = hist_r[idx_s];
  end
`endif

  // Registered segment output, aligned with the anode register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= BLANK_CODE;
    end else begin
      seg_r <= seg_nxt_s;
    end
  end

  assign seg_out = seg_r;
  assign gt_cnt  = gt_r;
  assign lt_cnt  = lt_r;
  assign eq_cnt  = eq_r;

endmodule

// File: tb/tb_cmp_result_display.sv
// Scoreboard bench for cmp_result_display (DIGITS=4, REFRESH_DIV=4, CNT_W=8).
`timescale 1ns/1ps
module tb_cmp_result_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] cmp_in;
  logic [7:0] seg_in;
  logic       clr;
  logic [3:0] an;
  logic [7:0] seg_out;
  logic [7:0] gt_cnt, lt_cnt, eq_cnt;

  typedef struct {
    int         tag;
    string      name;
    logic [2:0] mask;   // [0] anodes, [1] segments, [2] tallies
    logic [3:0] an;
    logic [7:0] seg;
    logic [7:0] gt;
    logic [7:0] lt;
    logic [7:0] eq;
  } exp_t;

  exp_t q[$];
  int   ncnt;
  int   n;
  int   checks   = 0;
  int   failures = 0;

  cmp_result_display #(
    .DIGITS(4), .REFRESH_DIV(4), .CNT_W(8), .BLANK_CODE(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cmp_in(cmp_in), .seg_in(seg_in),
    .clr(clr), .an(an), .seg_out(seg_out), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
  );

  always #5 clk = ~clk;

  // Hand-derived anode pattern after the k-th edge since reset release (4 cycles per digit).
  function automatic logic [3:0] an_exp(input int k);
    case (((k - 1) / 4) % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n = n + 1;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic push(input string nm, input logic [2:0] m, input logic [3:0] a,
                      input logic [7:0] s, input logic [7:0] g, input logic [7:0] l,
                      input logic [7:0] e);
    exp_t x;
    x.tag = ncnt; x.name = nm; x.mask = m; x.an = a; x.seg = s; x.gt = g; x.lt = l; x.eq = e;
    q.push_back(x);
  endtask

  task automatic cmp8(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", nm, got, want);
    end
  endtask

  // Monitor: the DUT presents outputs every cycle; compare entries due at this negedge.
  initial begin
    exp_t e;
    ncnt = 0;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag <= ncnt) begin
        e = q.pop_front();
        if (e.tag != ncnt) begin
          checks = checks + 1;
          failures = failures + 1;
          $display("FAIL %s stale entry tag=%0d now=%0d", e.name, e.tag, ncnt);
        end else begin
          if (e.mask[0]) cmp8({e.name, ".an"}, {4'b0000, an}, {4'b0000, e.an});
          if (e.mask[1]) cmp8({e.name, ".seg"}, seg_out, e.seg);
          if (e.mask[2]) begin
            cmp8({e.name, ".gt"}, gt_cnt, e.gt);
            cmp8({e.name, ".lt"}, lt_cnt, e.lt);
            cmp8({e.name, ".eq"}, eq_cnt, e.eq);
          end
        end
      end
      ncnt = ncnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst = 1'b1; in_valid = 1'b0; cmp_in = 2'b00; seg_in = 8'h00; clr = 1'b0; n = 0;
    tick(); tick();
    push("in_reset", 3'b111, 4'b1111, 8'hFF, 8'd0, 8'd0, 8'd0);
    tick();
    rst = 1'b0; n = 0;
    push("release", 3'b111, 4'b1111, 8'hFF, 8'd0, 8'd0, 8'd0);

    // Idle scan
    for (int i = 1; i <= 20; i++) begin
      tick();
      push("scan", 3'b111, an_exp(n), 8'hFF, 8'd0, 8'd0, 8'd0);
    end

    // History and tallies, one valid input per cycle
    in_valid = 1'b1; seg_in = 8'hC0; cmp_in = 2'b01;
    tick(); push("tally1", 3'b100, 4'b0, 8'h00, 8'd1, 8'd0, 8'd0);
    seg_in = 8'hF9; cmp_in = 2'b10;
    tick();
    seg_in = 8'hA4; cmp_in = 2'b00;
    tick(); push("hist_c0_slot1", 3'b011, 4'b1101, 8'hC0, 8'd0, 8'd0, 8'd0);
    seg_in = 8'hB0; cmp_in = 2'b11;
    tick();
    seg_in = 8'h99; cmp_in = 2'b01;
    tick();
    push("tally5", 3'b111, 4'b1011, 8'hF9, 8'd2, 8'd1, 8'd1);
    in_valid = 1'b0;
    tick(); push("hist_next_cycle", 3'b011, 4'b1011, 8'hA4, 8'd0, 8'd0, 8'd0);
    run_to(29); push("hist3", 3'b011, 4'b0111, 8'hF9, 8'd0, 8'd0, 8'd0);
    run_to(33); push("hist0", 3'b111, 4'b1110, 8'h99, 8'd2, 8'd1, 8'd1);
    run_to(37); push("hist1", 3'b011, 4'b1101, 8'hB0, 8'd0, 8'd0, 8'd0);
    run_to(41); push("hist2", 3'b011, 4'b1011, 8'hA4, 8'd0, 8'd0, 8'd0);

    // Equal tally saturation
    in_valid = 1'b1; seg_in = 8'hC0; cmp_in = 2'b00;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 253) push("eq_254", 3'b100, 4'b0, 8'h00, 8'd2, 8'd1, 8'd254);
      if (k == 254) push("eq_sat", 3'b100, 4'b0, 8'h00, 8'd2, 8'd1, 8'd255);
      if (k == 300) push("eq_hold", 3'b100, 4'b0, 8'h00, 8'd2, 8'd1, 8'd255);
    end

    // clr colliding with a valid input
    clr = 1'b1; cmp_in = 2'b01; seg_in = 8'hF9;
    tick(); c = n;
    push("clr_edge", 3'b111, an_exp(c), 8'hC0, 8'd0, 8'd0, 8'd0);
    clr = 1'b0; in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      push("after_clr", 3'b111, an_exp(n), 8'hFF, 8'd0, 8'd0, 8'd0);
    end

    // Reset in the middle of activity
    in_valid = 1'b1; cmp_in = 2'b01; seg_in = 8'h99;
    tick(); push("pre_rst", 3'b100, 4'b0, 8'h00, 8'd1, 8'd0, 8'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    push("mid_rst", 3'b111, 4'b1111, 8'hFF, 8'd0, 8'd0, 8'd0);
    tick();
    push("mid_rst_hold", 3'b111, 4'b1111, 8'hFF, 8'd0, 8'd0, 8'd0);
    rst = 1'b0; n = 0;
    push("rst_release", 3'b111, 4'b1111, 8'hFF, 8'd0, 8'd0, 8'd0);
    tick(); push("rst_first", 3'b111, 4'b1110, 8'hFF, 8'd0, 8'd0, 8'd0);
    run_to(5); push("rst_digit1", 3'b111, 4'b1101, 8'hFF, 8'd0, 8'd0, 8'd0);

    tick(); tick();
    checks = checks + 1;
    if (q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
